// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyMem
  } state_e;

  typedef enum logic {
    ReqIf,
    ReqMem
  } req_id_e;

  localparam int unsigned StreakMaxDefault = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Upstream request/response signals and the shared memory bus, bundled for the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // Fetch side
  logic                  if_request;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_done;
  // Data side
  logic                  mem_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_done;
  // Memory bus
  logic                  bus_req;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_we;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wmask;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_ready;
  // Status
  logic                  ovf_err;

  // Arbiter view
  modport slave (
    input  if_request, if_addr, mem_en, mem_addr, mem_we, mem_wdata, mem_wmask,
    input  bus_rdata, bus_ready,
    output if_rdata, if_done, mem_rdata, mem_done,
    output bus_req, bus_addr, bus_we, bus_wdata, bus_wmask, ovf_err
  );

  // Environment view (requesters plus memory)
  modport master (
    output if_request, if_addr, mem_en, mem_addr, mem_we, mem_wdata, mem_wmask,
    output bus_rdata, bus_ready,
    input  if_rdata, if_done, mem_rdata, mem_done,
    input  bus_req, bus_addr, bus_we, bus_wdata, bus_wmask, ovf_err
  );
endinterface

// File: rtl/arb_req_slot.sv
// One-deep pending slot: latches a request pulse and its payload until granted.
module arb_req_slot #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_i,
  input  logic             block_i,
  input  logic             clear_i,
  input  logic [Width-1:0] payload_i,
  output logic             pending_o,
  output logic [Width-1:0] payload_o,
  output logic             drop_o
);

  logic             pending_q, pending_d;
  logic [Width-1:0] payload_q, payload_d;

  // A fresh pulse wins over the grant clear so a same-edge request is not lost.
  always_comb begin
    pending_d = pending_q;
    payload_d = payload_q;
    if (capture_i && !block_i) begin
      pending_d = 1'b1;
      payload_d = payload_i;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      payload_q <= '0;
    end else begin
      pending_q <= pending_d;
      payload_q <= payload_d;
    end
  end

  assign pending_o = pending_q;
  assign payload_o = payload_q;
  assign drop_o    = capture_i && block_i;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory bus, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STREAK_MAX = StreakMaxDefault
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave arb_io
);

  localparam int unsigned MaskW   = DATA_W / 8;
  localparam int unsigned MemPayW = ADDR_W + 1 + DATA_W + MaskW;
  localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);

  state_e               state_q, state_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic                 bus_we_q, bus_we_d;
  logic [DATA_W-1:0]    bus_wdata_q, bus_wdata_d;
  logic [MaskW-1:0]     bus_wmask_q, bus_wmask_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic                 if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic                 ovf_err_q, ovf_err_d;

  logic                 pend_if, pend_mem, drop_if, drop_mem;
  logic                 grant_valid;
  req_id_e              grant_id;
  logic [ADDR_W-1:0]    slot_if_addr, slot_mem_addr;
  logic [MemPayW-1:0]   slot_mem_pay;
  logic                 slot_mem_we;
  logic [DATA_W-1:0]    slot_mem_wdata;
  logic [MaskW-1:0]     slot_mem_wmask;

  assign {slot_mem_addr, slot_mem_we, slot_mem_wdata, slot_mem_wmask} = slot_mem_pay;

  arb_req_slot #(.Width(ADDR_W)) u_slot_if (
    .clk_i     (clk),
    .rst_ni    (rst),
    .capture_i (arb_io.if_request),
    .block_i   (state_q == StBusyIf),
    .clear_i   (grant_valid && (grant_id == ReqIf)),
    .payload_i (arb_io.if_addr),
    .pending_o (pend_if),
    .payload_o (slot_if_addr),
    .drop_o    (drop_if)
  );

  arb_req_slot #(.Width(MemPayW)) u_slot_mem (
    .clk_i     (clk),
    .rst_ni    (rst),
    .capture_i (arb_io.mem_en),
    .block_i   (state_q == StBusyMem),
    .clear_i   (grant_valid && (grant_id == ReqMem)),
    .payload_i ({arb_io.mem_addr, arb_io.mem_we, arb_io.mem_wdata, arb_io.mem_wmask}),
    .pending_o (pend_mem),
    .payload_o (slot_mem_pay),
    .drop_o    (drop_mem)
  );

  // Data wins unless the fetch has waited through a full streak of data grants.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ReqMem;
    if (state_q == StIdle) begin
      if (pend_mem && !(pend_if && (streak_q == StreakW'(STREAK_MAX)))) begin
        grant_valid = 1'b1;
        grant_id    = ReqMem;
      end else if (pend_if) begin
        grant_valid = 1'b1;
        grant_id    = ReqIf;
      end
    end
  end

  // Next-state: issue a grant onto the bus, or retire the transaction on bus_ready.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ovf_err_d   = ovf_err_q | drop_if | drop_mem;
    unique case (state_q)
      StIdle: begin
        if (grant_valid && (grant_id == ReqMem)) begin
          state_d     = StBusyMem;
          bus_addr_d  = slot_mem_addr;
          bus_we_d    = slot_mem_we;
          bus_wdata_d = slot_mem_wdata;
          bus_wmask_d = slot_mem_wmask;
          if (pend_if) begin
            streak_d = (streak_q == StreakW'(STREAK_MAX)) ? streak_q : streak_q + StreakW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_valid) begin
          state_d     = StBusyIf;
          bus_addr_d  = slot_if_addr;
          bus_we_d    = 1'b0;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
          streak_d    = '0;
        end
      end
      StBusyIf: begin
        if (arb_io.bus_ready) begin
          if_rdata_d = arb_io.bus_rdata;
          if_done_d  = 1'b1;
          state_d    = StIdle;
        end
      end
      StBusyMem: begin
        if (arb_io.bus_ready) begin
          // Write completions leave the last read data untouched.
          if (!bus_we_q) mem_rdata_d = arb_io.bus_rdata;
          mem_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign arb_io.bus_req   = (state_q != StIdle);
  assign arb_io.bus_addr  = bus_addr_q;
  assign arb_io.bus_we    = bus_we_q;
  assign arb_io.bus_wdata = bus_wdata_q;
  assign arb_io.bus_wmask = bus_wmask_q;
  assign arb_io.if_rdata  = if_rdata_q;
  assign arb_io.if_done   = if_done_q;
  assign arb_io.mem_rdata = mem_rdata_q;
  assign arb_io.mem_done  = mem_done_q;
  assign arb_io.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts bus transactions
// and done pulses, a monitor compares them against what the DUT presents.
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int StreakMax   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) arb_if ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(StreakMax)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_io (arb_if)
  );

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [63:0] rdata;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t ifd_q[$];
  done_exp_t memd_q[$];
  bus_exp_t  mon_cur;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: who is on the bus (-1 none, 0 fetch, 1 data) and the slots.
  int          serving;
  bit          pend_if, pend_mem;
  logic [63:0] pif_addr;
  bus_exp_t    pmem;
  bit          cur_we;
  int          streak;
  bit          ovf_m;
  logic [63:0] m_if_rdata, m_mem_rdata;

  // Memory responder controls
  int          fix_lat     = -1;
  bit          spurious_en = 1'b0;
  bit          rdata_fixed = 1'b0;
  logic [63:0] fixed_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected no event (cycle %0d)", name, act, cyc);
  endtask

  task automatic model_reset();
    serving     = -1;
    pend_if     = 1'b0;
    pend_mem    = 1'b0;
    streak      = 0;
    ovf_m       = 1'b0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
    cur_we      = 1'b0;
    bus_q.delete();
    ifd_q.delete();
    memd_q.delete();
  endtask

  // One clock edge of the arbitration rules, applied to the values the DUT samples.
  task automatic model_step();
    int       prev;
    int       pick;
    bus_exp_t e;
    prev = serving;
    pick = -1;
    if (prev >= 0) begin
      if (arb_if.bus_ready) begin
        if (prev == 0) begin
          m_if_rdata = arb_if.bus_rdata;
          ifd_q.push_back('{cyc, m_if_rdata});
        end else begin
          if (!cur_we) m_mem_rdata = arb_if.bus_rdata;
          memd_q.push_back('{cyc, m_mem_rdata});
        end
        serving = -1;
      end
    end else begin
      if (pend_mem && pend_if) pick = (streak == StreakMax) ? 0 : 1;
      else if (pend_mem)       pick = 1;
      else if (pend_if)        pick = 0;
      if (pick == 1) begin
        streak = pend_if ? ((streak < StreakMax) ? streak + 1 : StreakMax) : 0;
        e = pmem;
        e.cyc = cyc;
        bus_q.push_back(e);
        cur_we   = pmem.we;
        pend_mem = 1'b0;
        serving  = 1;
      end else if (pick == 0) begin
        streak = 0;
        bus_q.push_back('{cyc, pif_addr, 1'b0, 64'h0, 8'h0});
        pend_if = 1'b0;
        serving = 0;
      end
    end
    if (arb_if.if_request) begin
      if (prev == 0) ovf_m = 1'b1;
      else begin
        pend_if  = 1'b1;
        pif_addr = arb_if.if_addr;
      end
    end
    if (arb_if.mem_en) begin
      if (prev == 1) ovf_m = 1'b1;
      else begin
        pend_mem = 1'b1;
        pmem     = '{0, arb_if.mem_addr, arb_if.mem_we, arb_if.mem_wdata, arb_if.mem_wmask};
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_step();
    end
  end

  initial forever begin
    @(negedge rst);
    model_reset();
  end

  // Memory side: answer each bus_req after a chosen latency, plus stray bus_ready when idle.
  initial begin
    int cnt;
    bit active;
    cnt    = 0;
    active = 1'b0;
    arb_if.bus_ready = 1'b0;
    arb_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arb_if.bus_ready = 1'b0;
        active = 1'b0;
      end else if (arb_if.bus_ready) begin
        arb_if.bus_ready = 1'b0;
      end else if (arb_if.bus_req) begin
        if (!active) begin
          active = 1'b1;
          cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
        end
        if (cnt == 0) begin
          arb_if.bus_ready = 1'b1;
          arb_if.bus_rdata = rdata_fixed ? fixed_rdata : {$urandom, $urandom};
          active = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
        if (spurious_en && ($urandom_range(0, 7) == 0)) begin
          arb_if.bus_ready = 1'b1;
          arb_if.bus_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a bus transaction or a done pulse.
  initial begin
    bit prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (arb_if.bus_req && !prev_req) begin
          if (bus_q.size() == 0) fail_unexp("bus_req_unexpected", arb_if.bus_addr);
          else begin
            mon_cur = bus_q.pop_front();
            chk("bus_req_cycle", 64'(cyc), 64'(mon_cur.cyc));
            chk("bus_addr", arb_if.bus_addr, mon_cur.addr);
            chk("bus_we", 64'(arb_if.bus_we), 64'(mon_cur.we));
            chk("bus_wmask", 64'(arb_if.bus_wmask), 64'(mon_cur.wmask));
            if (mon_cur.we) chk("bus_wdata", arb_if.bus_wdata, mon_cur.wdata);
          end
        end else if (arb_if.bus_req) begin
          chk("bus_hold_addr", arb_if.bus_addr, mon_cur.addr);
          chk("bus_hold_we", 64'(arb_if.bus_we), 64'(mon_cur.we));
          if (mon_cur.we) chk("bus_hold_wdata", arb_if.bus_wdata, mon_cur.wdata);
        end
        prev_req = arb_if.bus_req;
        if (arb_if.if_done) begin
          if (ifd_q.size() == 0) fail_unexp("if_done_unexpected", arb_if.if_rdata);
          else begin
            done_exp_t d;
            d = ifd_q.pop_front();
            chk("if_done_cycle", 64'(cyc), 64'(d.cyc));
            chk("if_rdata", arb_if.if_rdata, d.rdata);
          end
        end
        if (arb_if.mem_done) begin
          if (memd_q.size() == 0) fail_unexp("mem_done_unexpected", arb_if.mem_rdata);
          else begin
            done_exp_t d;
            d = memd_q.pop_front();
            chk("mem_done_cycle", 64'(cyc), 64'(d.cyc));
            chk("mem_rdata", arb_if.mem_rdata, d.rdata);
          end
        end
        chk("ovf_err", 64'(arb_if.ovf_err), 64'(ovf_m));
      end
    end
  end

  task automatic pulse(input bit do_if, input logic [63:0] ia, input bit do_mem,
                       input logic [63:0] ma, input bit we, input logic [63:0] wd,
                       input logic [7:0] wm);
    @(negedge clk);
    arb_if.if_request = do_if;
    arb_if.if_addr    = ia;
    arb_if.mem_en     = do_mem;
    arb_if.mem_addr   = ma;
    arb_if.mem_we     = we;
    arb_if.mem_wdata  = wd;
    arb_if.mem_wmask  = wm;
    @(negedge clk);
    arb_if.if_request = 1'b0;
    arb_if.mem_en     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(serving < 0 && !pend_if && !pend_mem && bus_q.size() == 0 &&
             ifd_q.size() == 0 && memd_q.size() == 0 && !arb_if.bus_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got %0d cycles expected fewer than %0d", name, n, budget);
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got time %0t expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reissue;
    arb_if.if_request = 1'b0;
    arb_if.if_addr    = '0;
    arb_if.mem_en     = 1'b0;
    arb_if.mem_addr   = '0;
    arb_if.mem_we     = 1'b0;
    arb_if.mem_wdata  = '0;
    arb_if.mem_wmask  = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 64'(arb_if.bus_req), 64'h0);
    chk("rst_bus_addr", arb_if.bus_addr, 64'h0);
    chk("rst_if_done", 64'(arb_if.if_done), 64'h0);
    chk("rst_mem_done", 64'(arb_if.mem_done), 64'h0);
    chk("rst_if_rdata", arb_if.if_rdata, 64'h0);
    chk("rst_ovf_err", 64'(arb_if.ovf_err), 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single uncontended fetch, memory answers 3 cycles after bus_req
    fix_lat = 3; rdata_fixed = 1'b1; fixed_rdata = 64'h13;
    pulse(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    chk("lat_pending_cycle", 64'(arb_if.bus_req), 64'h0);
    @(negedge clk);
    chk("lat_bus_req_cycle2", 64'(arb_if.bus_req), 64'h1);
    chk("fetch_bus_we", 64'(arb_if.bus_we), 64'h0);
    chk("fetch_bus_addr", arb_if.bus_addr, 64'h8000_0000);
    wait_idle("single_fetch", 50);
    chk("fetch_rdata_hold", arb_if.if_rdata, 64'h13);
    rdata_fixed = 1'b0;

    // Simultaneous fetch and data write: data goes first
    fix_lat = 2;
    pulse(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'hDEAD, 8'hFF);
    @(negedge clk);
    chk("simul_first_we", 64'(arb_if.bus_we), 64'h1);
    chk("simul_first_addr", arb_if.bus_addr, 64'h2000);
    wait_idle("simultaneous", 50);

    // Overflow: second data pulse while data is in service is dropped
    fix_lat = 4;
    pulse(1'b0, 64'h0, 1'b1, 64'h3000, 1'b0, 64'h0, 8'h0);
    pulse(1'b0, 64'h0, 1'b1, 64'h3008, 1'b0, 64'h0, 8'h0);
    chk("ovf_set", 64'(arb_if.ovf_err), 64'h1);
    wait_idle("overflow", 50);
    chk("ovf_sticky", 64'(arb_if.ovf_err), 64'h1);

    // Overwrite: two fetch pulses while data is in service collapse into one fetch
    fix_lat = 6;
    pulse(1'b0, 64'h0, 1'b1, 64'h4000, 1'b0, 64'h0, 8'h0);
    pulse(1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    pulse(1'b1, 64'h104, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    wait_idle("overwrite", 60);

    // Starvation attempt: fetch pending, data re-issued at every data completion
    fix_lat = 1;
    pulse(1'b0, 64'h0, 1'b1, 64'h5000, 1'b0, 64'h0, 8'h0);
    pulse(1'b1, 64'h6000, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    reissue = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      arb_if.mem_en = 1'b0;
      if (arb_if.mem_done && reissue < 5) begin
        arb_if.mem_en   = 1'b1;
        arb_if.mem_addr = 64'h5000 + 64'(reissue + 1) * 64'h8;
        arb_if.mem_we   = 1'b0;
        reissue++;
      end
    end
    arb_if.mem_en = 1'b0;
    wait_idle("starvation", 60);

    // Randomized traffic with random latency and stray bus_ready
    fix_lat = -1; spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      arb_if.if_request = ($urandom_range(0, 3) == 0);
      arb_if.if_addr    = {$urandom, $urandom};
      arb_if.mem_en     = ($urandom_range(0, 3) == 0);
      arb_if.mem_addr   = {$urandom, $urandom};
      arb_if.mem_we     = 1'($urandom_range(0, 1));
      arb_if.mem_wdata  = {$urandom, $urandom};
      arb_if.mem_wmask  = 8'($urandom);
    end
    @(negedge clk);
    arb_if.if_request = 1'b0;
    arb_if.mem_en     = 1'b0;
    spurious_en       = 1'b0;
    wait_idle("random", 100);

    // Asynchronous reset in the middle of a data transaction with a fetch pending
    fix_lat = 8;
    pulse(1'b0, 64'h0, 1'b1, 64'h7000, 1'b1, 64'h1234, 8'h0F);
    pulse(1'b1, 64'h7100, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bus_req", 64'(arb_if.bus_req), 64'h0);
    chk("async_rst_mem_done", 64'(arb_if.mem_done), 64'h0);
    chk("async_rst_ovf_err", 64'(arb_if.ovf_err), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_slots_empty", 64'(arb_if.bus_req), 64'h0);
    end
    fix_lat = 2; rdata_fixed = 1'b1; fixed_rdata = 64'h55;
    pulse(1'b1, 64'h7200, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
    wait_idle("post_reset", 50);
    chk("post_rst_if_rdata", arb_if.if_rdata, 64'h55);

    chk("left_bus_exp", 64'(bus_q.size()), 64'h0);
    chk("left_if_done_exp", 64'(ifd_q.size()), 64'h0);
    chk("left_mem_done_exp", 64'(memd_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory bus between the instruction-fetch and data-access request streams leaving the MMU.
- Upstream request inputs are single-cycle pulses with translated addresses. The block latches each pulse into a per-requester pending slot.
- It arbitrates (data priority with fetch anti-starvation), sequences one bus transaction at a time, and returns read data with a one-cycle done pulse.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, data width; DATA_W/8 byte-mask bits
STREAK_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (rst=0 resets)
if_request  in  1  fetch request pulse
if_addr  in  ADDR_W  fetch address, valid with if_request
if_rdata  out  DATA_W  fetch read data, valid with if_done
if_done  out  1  fetch completion pulse
mem_en  in  1  data request pulse
mem_addr  in  ADDR_W  data address, valid with mem_en
mem_we  in  1  1=write, 0=read
mem_wdata  in  DATA_W  write data
mem_wmask  in  DATA_W/8  write byte enables
mem_rdata  out  DATA_W  data read data, valid with mem_done
mem_done  out  1  data completion pulse (reads and writes)
bus_req  out  1  bus transaction request, held until bus_ready
bus_addr  out  ADDR_W  bus address
bus_we  out  1  bus write enable
bus_wdata  out  DATA_W  bus write data
bus_wmask  out  DATA_W/8  bus byte enables
bus_rdata  in  DATA_W  bus read data, valid with bus_ready
bus_ready  in  1  bus completion, one cycle
ovf_err  out  1  sticky: request pulse arrived while that requester was in service

Behaviour:
- Reset (rst=0, async): all outputs 0, both slots empty, FSM=IDLE, streak=0. bus_req drops immediately even mid-transaction. No done pulse is emitted for an aborted transaction.
- Slot capture: a pulse at edge E sets pending and latches the payload.
  - If the slot is already pending but not issued, the new payload overwrites it.
  - If that requester is in service, the pulse is dropped and ovf_err is set. ovf_err clears only on reset.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- IDLE with no pending slot: stay.
- IDLE with one pending slot: grant it.
- IDLE with both pending: grant MEM unless streak==STREAK_MAX, in which case grant IF.
- Streak update on each grant:
  - MEM grant with IF pending: streak+1, saturating at STREAK_MAX.
  - IF grant, or any grant with IF not pending: streak=0.
- On grant, the slot payload is registered onto bus_*, bus_req=1 from the next cycle, and the slot clears.
  - IF grants drive bus_we=0 and bus_wmask=0.
- Latency: pulse in cycle 0 -> pending in cycle 1 -> bus_req=1 in cycle 2 (uncontended).
- BUSY_x: bus_addr/we/wdata/wmask held stable while bus_req=1.
  - On bus_ready: register bus_rdata into x_rdata, pulse x_done for exactly one cycle after, drop bus_req, return to IDLE.
  - The next grant may issue the cycle after bus_ready, giving back-to-back bus_req with a one-cycle gap.
- x_rdata holds its value until the next completion for that requester. For writes, mem_rdata is undefined; leave it unchanged.
- bus_ready while IDLE: ignored.
- A pulse arriving in the same cycle as its own done pulse is accepted; the requester is no longer in service.
- A simultaneous if_request and mem_en pulse both capture.

Decomposition:
- mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_MEM), requester-id enum (REQ_IF, REQ_MEM), STREAK_MAX default constant.
- Sub-module arb_req_slot: pending flag plus payload register, parameterized payload width. Instantiated twice (fetch payload = addr; data payload = addr+we+wdata+wmask).

Test Plan:
- Single fetch: if_request pulse, if_addr=0x8000_0000; bus_ready 3 cycles after bus_req with bus_rdata=0x0000_0013 -> bus_req rises cycle 2, bus_we=0, if_done one cycle with if_rdata=0x13.
- Simultaneous pulses: fetch 0x1000 and data write 0x2000 with wdata=0xDEAD, wmask=0xFF -> data transaction first (bus_we=1), then fetch, each done exactly once.
- Starvation: fetch pending, data pulses re-issued every completion -> exactly 4 data grants, then fetch granted, streak back to 0.
- Overflow: second mem_en while data in service -> pulse dropped, ovf_err=1 until reset, one mem_done only.
- Async reset mid BUSY_MEM: rst=0 between clock edges -> bus_req=0 immediately, no mem_done, pending slots clear; post-reset pulses serviced normally.
- Overwrite: two if_request pulses (0x100 then 0x104) while data in service -> single fetch to 0x104.
